// File: rtl/pipeline_stall_ctrl_if.sv
// Stall/flush control bundle between pipeline stages and the stall controller.
// master drives requests and exceptions; slave is the controller.
interface pipeline_stall_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              stall_req_if;
    logic              stall_req_id;
    logic              stall_req_ex;
    logic              stall_req_mem;
    logic              exc_valid;
    logic [ADDR_W-1:0] exc_target;
    logic [5:0]        stall;
    logic              flush;
    logic [ADDR_W-1:0] flush_pc;
    logic              stall_timeout;

    modport master (
        output stall_req_if, stall_req_id, stall_req_ex, stall_req_mem,
        output exc_valid, exc_target,
        input  stall, flush, flush_pc, stall_timeout
    );

    modport slave (
        input  stall_req_if, stall_req_id, stall_req_ex, stall_req_mem,
        input  exc_valid, exc_target,
        output stall, flush, flush_pc, stall_timeout
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush controller: monotone stall vector, exception flush, watchdog.
// Define PIPE_PERF_CNT_EN to add stall-cycle and flush-event counters.
module pipeline_stall_ctrl #(
    parameter int ADDR_W        = 32,
    parameter int FLUSH_CYCLES  = 1,
    parameter int STALL_TIMEOUT = 1024
) (
    input logic                  clk,
    input logic                  rst,
    pipeline_stall_ctrl_if.slave bus
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]          perf_stall_cycles,
    output logic [31:0]          perf_flush_events
`endif
);
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int RUN_W = $clog2(STALL_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_FREEZE,
        S_FLUSH
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  flush_cnt, cnt_n;
    logic [RUN_W-1:0]  stall_run;
    logic [ADDR_W-1:0] flush_pc_q;
    logic              timeout_q;
    logic [5:0]        stall_c;
    logic              flush_c;
    logic              accept;
    logic              stalled;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_n;
            flush_cnt <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = flush_cnt;
        stall_c = 6'b000000;
        flush_c = 1'b0;
        accept  = 1'b0;
        unique case (state)
            S_RUN: begin
                if (bus.exc_valid) begin
                    stall_c = 6'b111111;
                    accept  = 1'b1;
                    state_n = S_FREEZE;
                end else begin
                    priority case (1'b1)
                        bus.stall_req_mem: stall_c = 6'b011111;
                        bus.stall_req_ex:  stall_c = 6'b001111;
                        bus.stall_req_id:  stall_c = 6'b000111;
                        bus.stall_req_if:  stall_c = 6'b000011;
                        default:           stall_c = 6'b000000;
                    endcase
                end
            end
            S_FREEZE: begin
                flush_c = 1'b1;
                if (FLUSH_CYCLES == 1) begin
                    state_n = S_RUN;
                end else begin
                    state_n = S_FLUSH;
                    cnt_n   = CNT_W'(FLUSH_CYCLES - 2);
                end
            end
            S_FLUSH: begin
                flush_c = 1'b1;
                if (flush_cnt == '0) begin
                    state_n = S_RUN;
                end else begin
                    cnt_n = flush_cnt - 1'b1;
                end
            end
            default: state_n = S_RUN;
        endcase
        // Outputs stay quiet for the whole reset assertion, not only after the edge.
        if (rst) begin
            stall_c = 6'b000000;
            accept  = 1'b0;
        end
    end

    assign stalled = (stall_c != 6'b000000);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_pc_q <= '0;
        end else if (accept) begin
            flush_pc_q <= bus.exc_target;
        end
    end

    // Timeout sets on the same edge the run length reaches STALL_TIMEOUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_run <= '0;
            timeout_q <= 1'b0;
        end else if (stalled) begin
            if (stall_run != RUN_W'(STALL_TIMEOUT)) begin
                stall_run <= stall_run + 1'b1;
            end
            if (stall_run >= RUN_W'(STALL_TIMEOUT - 1)) begin
                timeout_q <= 1'b1;
            end
        end else begin
            stall_run <= '0;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_flush_events <= '0;
        end else begin
            if (stalled && perf_stall_cycles != 32'hFFFF_FFFF) begin
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
            end
            if (accept && perf_flush_events != 32'hFFFF_FFFF) begin
                perf_flush_events <= perf_flush_events + 1'b1;
            end
        end
    end
`endif

    assign bus.stall         = stall_c;
    assign bus.flush         = flush_c;
    assign bus.flush_pc      = flush_pc_q;
    assign bus.stall_timeout = timeout_q;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: directed scenarios then random traffic.
// A behavioural model pushes expectations; a monitor pops and compares each cycle.
module tb_pipeline_stall_ctrl;
    localparam int FC = 3;
    localparam int TO = 4;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] fpc;
        logic        to;
    } exp_t;

    logic clk;
    logic rst;
    pipeline_stall_ctrl_if #(.ADDR_W(32)) bus ();
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_s;
    logic [31:0] perf_f;
`endif

    pipeline_stall_ctrl #(
        .ADDR_W        (32),
        .FLUSH_CYCLES  (FC),
        .STALL_TIMEOUT (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef PIPE_PERF_CNT_EN
        ,
        .perf_stall_cycles (perf_s),
        .perf_flush_events (perf_f)
`endif
    );

    exp_t        sb[$];
    int          checks = 0;
    int          passes = 0;
    int          flush_left = 0;
    int          run_len = 0;
    bit          to_m = 0;
    logic [31:0] fpc_m = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // One cycle of stimulus; the model predicts this cycle's outputs then advances.
    task automatic step(input bit r, input logic [3:0] req, input bit exc,
                        input logic [31:0] tgt);
        exp_t e;
        int   h;
        @(posedge clk);
        #1;
        rst               = r;
        bus.stall_req_if  = req[0];
        bus.stall_req_id  = req[1];
        bus.stall_req_ex  = req[2];
        bus.stall_req_mem = req[3];
        bus.exc_valid     = exc;
        bus.exc_target    = tgt;
        if (r) begin
            flush_left = 0;
            run_len    = 0;
            to_m       = 0;
            fpc_m      = '0;
            e.stall = 6'd0;
            e.flush = 1'b0;
            e.fpc   = 32'd0;
            e.to    = 1'b0;
            sb.push_back(e);
            return;
        end
        e.flush = (flush_left > 0);
        e.fpc   = fpc_m;
        e.to    = to_m;
        if (flush_left > 0) begin
            e.stall = 6'd0;
        end else if (exc) begin
            e.stall = 6'b111111;
        end else begin
            h = -1;
            for (int i = 0; i < 4; i++) if (req[i]) h = i + 1;
            e.stall = (h < 0) ? 6'd0 : 6'((1 << (h + 1)) - 1);
        end
        sb.push_back(e);
        if (flush_left > 0) begin
            flush_left--;
        end else if (exc) begin
            flush_left = FC;
            fpc_m      = tgt;
        end
        if (e.stall != 6'd0) begin
            run_len++;
            if (run_len >= TO) to_m = 1;
        end else begin
            run_len = 0;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("stall", 32'(bus.stall), 32'(e.stall));
                check("flush", 32'(bus.flush), 32'(e.flush));
                check("flush_pc", bus.flush_pc, e.fpc);
                check("stall_timeout", 32'(bus.stall_timeout), 32'(e.to));
            end
        end
    end

    initial begin : driver
        rst               = 1'b1;
        bus.stall_req_if  = 1'b0;
        bus.stall_req_id  = 1'b0;
        bus.stall_req_ex  = 1'b0;
        bus.stall_req_mem = 1'b0;
        bus.exc_valid     = 1'b0;
        bus.exc_target    = '0;
        step(1, 4'b0000, 0, 0);
        step(1, 4'b0000, 0, 0);
        step(0, 4'b0000, 0, 0);
        step(0, 4'b0010, 0, 0);
        step(0, 4'b0000, 0, 0);
        step(0, 4'b1101, 0, 0);
        step(0, 4'b0000, 0, 0);
        // exception with a pending mem stall, second exception inside the window
        step(0, 4'b1000, 1, 32'h8000_0180);
        step(0, 4'b1111, 0, 0);
        step(0, 4'b0100, 1, 32'h1234_5678);
        step(0, 4'b1000, 0, 0);
        step(0, 4'b0000, 0, 0);
        step(0, 4'b0000, 0, 0);
        // watchdog: 3 stalled cycles stay below, 4 trip it
        for (int i = 0; i < 3; i++) step(0, 4'b0100, 0, 0);
        step(0, 4'b0000, 0, 0);
        step(0, 4'b0000, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 4'b0100, 0, 0);
        step(0, 4'b0000, 0, 0);
        step(0, 4'b0000, 0, 0);
        // reset during the second flush cycle
        step(0, 4'b0000, 1, 32'hDEAD_BEEC);
        step(0, 4'b0000, 0, 0);
        step(1, 4'b0000, 0, 0);
        step(0, 4'b0000, 0, 0);
        step(0, 4'b0000, 0, 0);
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 63) == 0),
                 4'($urandom & $urandom),
                 ($urandom_range(0, 7) == 0),
                 $urandom & 32'hFFFF_FFFC);
        end
        step(0, 4'b0000, 0, 0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() == 0) passes++;
        else $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
